// File: rtl/rv_dmem_pkg.sv
// rtl/rv_dmem_pkg.sv - shared encodings and defaults for the rv_dmem_mmio data memory
package rv_dmem_pkg;

    localparam logic [2:0] W_BYTE = 3'd0;
    localparam logic [2:0] W_HALF = 3'd1;
    localparam logic [2:0] W_WORD = 3'd2;

    localparam logic [31:0] DEF_STATUS_ADDR = 32'h1001200c;
    localparam logic [31:0] DEF_PASS_CODE   = 32'h00400000;
    localparam logic [31:0] DEF_FAIL_CODE   = 32'h00080000;

    localparam int PASS_CNT_W = 8;

    // Byte count of a store; any width with bit1 set is a full word.
    function automatic logic [2:0] store_bytes(input logic [2:0] width);
        logic [2:0] n;
        case (width[1:0])
            W_BYTE[1:0]: n = 3'd1;
            W_HALF[1:0]: n = 3'd2;
            default:     n = 3'd4;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/rv_dmem_stack.sv
// rtl/rv_dmem_stack.sv - bounded 32-bit LIFO behind address 0 with sticky over/underflow flags
module rv_dmem_stack #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top_data,
    output logic        ovf,
    output logic        unf
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [PTR_W:0]   sp;
    logic [PTR_W:0]   sp_m1;
    logic             empty;
    logic             full;
    logic             replace;
    logic             wr_en;
    logic [PTR_W-1:0] wr_idx;

    assign sp_m1   = sp - 1'b1;
    assign empty   = (sp == '0);
    assign full    = (sp == (PTR_W+1)'(DEPTH));
    // Push and pop together on a non-empty stack overwrite the top in place.
    assign replace = push && pop && !empty;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        if (replace) begin
            wr_en  = 1'b1;
            wr_idx = sp_m1[PTR_W-1:0];
        end else if (push && !full) begin
            wr_en  = 1'b1;
            wr_idx = sp[PTR_W-1:0];
        end
    end

    assign top_data = empty ? 32'h0 : mem[sp_m1[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else if (push && !replace) begin
            if (full) begin
                ovf <= 1'b1;
            end else begin
                sp <= sp + 1'b1;
            end
        end else if (pop && !push) begin
            if (empty) begin
                unf <= 1'b1;
            end else begin
                sp <= sp_m1;
            end
        end
    end

endmodule

// File: rtl/rv_dmem_mmio.sv
// rtl/rv_dmem_mmio.sv - byte RAM, stack window and test-status register; RV_DMEM_STATS_EN adds cycle_cnt
module rv_dmem_mmio
    import rv_dmem_pkg::*;
#(
    parameter int          ADDR_W      = 20,
    parameter int          STACK_DEPTH = 16,
    parameter logic [31:0] STATUS_ADDR = DEF_STATUS_ADDR,
    parameter logic [31:0] PASS_CODE   = DEF_PASS_CODE,
    parameter logic [31:0] FAIL_CODE   = DEF_FAIL_CODE,
    parameter int          PASS_TARGET = 2
) (
    input  logic                  clk,
    input  logic                  c_arst,
    input  logic                  c_dmem_store,
    input  logic [2:0]            dmem_store_width,
    input  logic [32:0]           dmem_store_addr,
    input  logic [31:0]           dmem_store_data,
    input  logic                  c_dmem_load,
    input  logic [32:0]           dmem_load_addr,
    output logic [31:0]           dmem_load_data,
    output logic                  test_pass,
    output logic                  test_fail,
    output logic [PASS_CNT_W-1:0] pass_cnt,
    output logic                  stack_ovf,
    output logic                  stack_unf
`ifdef RV_DMEM_STATS_EN
    ,
    output logic [31:0]           cycle_cnt
`endif
);

    localparam int RAM_BYTES = 1 << ADDR_W;

    logic [7:0]            ram [RAM_BYTES];
    logic [31:0]           st_a;
    logic [31:0]           ld_a;
    logic                  st_stack;
    logic                  st_status;
    logic                  st_ram;
    logic                  ld_stack;
    logic                  ld_status;
    logic [2:0]            st_nbytes;
    logic [ADDR_W-1:0]     st_idx;
    logic [ADDR_W-1:0]     ld_idx;
    logic [31:0]           ram_word;
    logic [31:0]           stack_top;
    logic                  running;
    logic [PASS_CNT_W-1:0] pass_next;
    logic                  unused_bits;

    assign unused_bits = ^{dmem_store_addr[32], dmem_load_addr[32], dmem_store_width[2]};

    assign st_a      = dmem_store_addr[31:0];
    assign ld_a      = dmem_load_addr[31:0];
    assign st_stack  = c_dmem_store && (st_a == 32'h0);
    assign st_status = c_dmem_store && (st_a != 32'h0) && (st_a == STATUS_ADDR);
    assign st_ram    = c_dmem_store && !st_stack && !st_status;
    assign ld_stack  = (ld_a == 32'h0);
    assign ld_status = !ld_stack && (ld_a == STATUS_ADDR);
    assign st_nbytes = store_bytes(dmem_store_width);
    assign st_idx    = st_a[ADDR_W-1:0];
    assign ld_idx    = ld_a[ADDR_W-1:0];

    rv_dmem_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (c_arst),
        .push      (st_stack),
        .pop       (c_dmem_load && ld_stack),
        .push_data (dmem_store_data),
        .top_data  (stack_top),
        .ovf       (stack_ovf),
        .unf       (stack_unf)
    );

    // Byte lanes wrap around the top of the RAM for unaligned accesses.
    always_ff @(posedge clk) begin
        if (st_ram) begin
            for (int k = 0; k < 4; k++) begin
                if (k < int'(st_nbytes)) begin
                    ram[st_idx + ADDR_W'(k)] <= dmem_store_data[8*k +: 8];
                end
            end
        end
    end

    assign ram_word = {ram[ld_idx + ADDR_W'(3)], ram[ld_idx + ADDR_W'(2)],
                       ram[ld_idx + ADDR_W'(1)], ram[ld_idx]};

    always_comb begin
        dmem_load_data = ram_word;
        if (ld_stack) begin
            dmem_load_data = stack_top;
        end else if (ld_status) begin
            dmem_load_data = {22'h0, test_fail, test_pass, pass_cnt};
        end
    end

    assign running   = !(test_pass || test_fail);
    assign pass_next = (pass_cnt == '1) ? pass_cnt : pass_cnt + 1'b1;

    always_ff @(posedge clk or posedge c_arst) begin
        if (c_arst) begin
            pass_cnt  <= '0;
            test_pass <= 1'b0;
            test_fail <= 1'b0;
        end else if (st_status && running) begin
            if (dmem_store_data == PASS_CODE) begin
                pass_cnt <= pass_next;
                if (32'(pass_next) >= 32'(PASS_TARGET)) begin
                    test_pass <= 1'b1;
                end
            end else if (dmem_store_data == FAIL_CODE) begin
                test_fail <= 1'b1;
            end
        end
    end

`ifdef RV_DMEM_STATS_EN
    always_ff @(posedge clk or posedge c_arst) begin
        if (c_arst) begin
            cycle_cnt <= '0;
        end else if (running && (cycle_cnt != '1)) begin
            cycle_cnt <= cycle_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// tb/tb_rv_dmem_mmio.sv - table, directed and random checks of rv_dmem_mmio against a queue/array model
module tb_rv_dmem_mmio;

    localparam int          ADDR_W = 10;
    localparam int          DEPTH  = 4;
    localparam logic [32:0] SADDR  = 33'h0_1001200c;
    localparam logic [31:0] PASS_V = 32'h00400000;
    localparam logic [31:0] FAIL_V = 32'h00080000;
    localparam int          TARGET = 2;
    localparam int          NBYTES = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        c_arst = 1'b1;
    logic        c_dmem_store = 1'b0;
    logic [2:0]  dmem_store_width = 3'd0;
    logic [32:0] dmem_store_addr = '0;
    logic [31:0] dmem_store_data = '0;
    logic        c_dmem_load = 1'b0;
    logic [32:0] dmem_load_addr = 33'h4;
    logic [31:0] dmem_load_data;
    logic        test_pass;
    logic        test_fail;
    logic [7:0]  pass_cnt;
    logic        stack_ovf;
    logic        stack_unf;
`ifdef RV_DMEM_STATS_EN
    logic [31:0] cycle_cnt;
    logic [31:0] cc_snap;
`endif

    int vectors = 0;
    int miscompares = 0;

    logic [7:0]  m_ram [NBYTES];
    logic [31:0] m_stack [$];
    logic        m_pass, m_fail, m_ovf, m_unf;
    int          m_cnt;

    typedef struct {
        logic        st;
        logic [2:0]  w;
        logic [32:0] sa;
        logic [31:0] sd;
        logic        ld;
        logic [32:0] la;
        logic        chk;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [8];

    rv_dmem_mmio #(
        .ADDR_W      (ADDR_W),
        .STACK_DEPTH (DEPTH),
        .STATUS_ADDR (SADDR[31:0]),
        .PASS_CODE   (PASS_V),
        .FAIL_CODE   (FAIL_V),
        .PASS_TARGET (TARGET)
    ) dut (
        .clk              (clk),
        .c_arst           (c_arst),
        .c_dmem_store     (c_dmem_store),
        .dmem_store_width (dmem_store_width),
        .dmem_store_addr  (dmem_store_addr),
        .dmem_store_data  (dmem_store_data),
        .c_dmem_load      (c_dmem_load),
        .dmem_load_addr   (dmem_load_addr),
        .dmem_load_data   (dmem_load_data),
        .test_pass        (test_pass),
        .test_fail        (test_fail),
        .pass_cnt         (pass_cnt),
        .stack_ovf        (stack_ovf),
        .stack_unf        (stack_unf)
`ifdef RV_DMEM_STATS_EN
        ,
        .cycle_cnt        (cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int nbytes(input logic [2:0] w);
        if (w[1]) return 4;
        if (w[0]) return 2;
        return 1;
    endfunction

    function automatic logic [31:0] model_load(input logic [32:0] la);
        logic [31:0] a;
        logic [31:0] r;
        a = la[31:0];
        if (a == 32'h0) return (m_stack.size() == 0) ? 32'h0 : m_stack[m_stack.size()-1];
        r = '0;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = m_ram[(int'(a % NBYTES) + k) % NBYTES];
        return r;
    endfunction

    task automatic model_reset();
        m_stack.delete();
        m_pass = 0; m_fail = 0; m_ovf = 0; m_unf = 0; m_cnt = 0;
    endtask

    task automatic model_apply(input logic st, input logic [2:0] w, input logic [32:0] sa,
                               input logic [31:0] sd, input logic ld, input logic [32:0] la);
        logic push, pop;
        push = st && (sa[31:0] == 32'h0);
        pop  = ld && (la[31:0] == 32'h0);
        if (push && pop && m_stack.size() > 0) m_stack[m_stack.size()-1] = sd;
        else if (push) begin
            if (m_stack.size() == DEPTH) m_ovf = 1;
            else m_stack.push_back(sd);
        end else if (pop) begin
            if (m_stack.size() == 0) m_unf = 1;
            else void'(m_stack.pop_back());
        end
        if (st && !push && sa[31:0] == SADDR[31:0]) begin
            if (!(m_pass || m_fail)) begin
                if (sd == PASS_V) begin
                    if (m_cnt < 255) m_cnt++;
                    if (m_cnt >= TARGET) m_pass = 1;
                end else if (sd == FAIL_V) m_fail = 1;
            end
        end else if (st && !push) begin
            for (int k = 0; k < nbytes(w); k++)
                m_ram[(int'(sa[31:0] % NBYTES) + k) % NBYTES] = sd[8*k +: 8];
        end
    endtask

    task automatic check_flags(input string name);
        check32({name, "_flags"}, {28'h0, test_pass, test_fail, stack_ovf, stack_unf},
                {28'h0, m_pass, m_fail, m_ovf, m_unf});
        check32({name, "_pass_cnt"}, {24'h0, pass_cnt}, m_cnt);
    endtask

    task automatic step(input logic st, input logic [2:0] w, input logic [32:0] sa, input logic [31:0] sd,
                        input logic ld, input logic [32:0] la, input logic chk, input logic [31:0] exp,
                        input string name);
        @(negedge clk);
        c_dmem_store = st; dmem_store_width = w; dmem_store_addr = sa; dmem_store_data = sd;
        c_dmem_load = ld; dmem_load_addr = la;
        #1;
        if (chk) check32(name, dmem_load_data, exp);
        @(posedge clk);
        #1;
        model_apply(st, w, sa, sd, ld, la);
        check_flags(name);
        c_dmem_store = 1'b0;
        c_dmem_load  = 1'b0;
    endtask

    task automatic push(input logic [31:0] d);
        step(1'b1, 3'd2, 33'h0, d, 1'b0, 33'h4, 1'b0, 32'h0, "push");
    endtask

    task automatic pop(input logic [31:0] exp, input string name);
        step(1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h0, 1'b1, exp, name);
    endtask

    task automatic status_store(input logic [31:0] d);
        step(1'b1, 3'd2, SADDR, d, 1'b0, 33'h4, 1'b0, 32'h0, "status");
    endtask

    task automatic reset_dut(input string name);
        @(negedge clk);
        c_arst = 1'b1;
        #1;
        check32({name, "_async_clear"}, {24'h0, test_pass, test_fail, stack_ovf, stack_unf, pass_cnt[3:0]}, 32'h0);
`ifdef RV_DMEM_STATS_EN
        check32({name, "_cycle_cnt"}, cycle_cnt, 32'h0);
`endif
        model_reset();
        @(negedge clk);
        c_arst = 1'b0;
    endtask

    function automatic logic [32:0] rand_ram_addr();
        logic [32:0] a;
        a = {1'($urandom), $urandom};
        if (a[31:0] == 32'h0 || a[31:0] == SADDR[31:0]) a[31:0] = 32'h4;
        return a;
    endfunction

    initial begin
        tbl[0] = '{1'b1, 3'd2, 33'h100, 32'hdeadbeef, 1'b0, 33'h4, 1'b0, 32'h0};
        tbl[1] = '{1'b1, 3'd0, 33'h102, 32'h00000055, 1'b1, 33'h100, 1'b1, 32'hdeadbeef};
        tbl[2] = '{1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h100, 1'b1, 32'hde55beef};
        tbl[3] = '{1'b1, 3'd1, 33'h3ff, 32'h0000cafe, 1'b0, 33'h4, 1'b0, 32'h0};
        tbl[4] = '{1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h3ff, 1'b1, 32'h0000cafe};
        tbl[5] = '{1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h400, 1'b1, 32'h000000ca};
        tbl[6] = '{1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h3fc, 1'b1, 32'hfe000000};
        tbl[7] = '{1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h1_00000100, 1'b1, 32'hde55beef};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_flags("reset");
        @(negedge clk);
        c_arst = 1'b0;
`ifdef RV_DMEM_STATS_EN
        check32("cycle_cnt_reset", cycle_cnt, 32'h0);
        repeat (5) @(negedge clk);
        check32("cycle_cnt_run", cycle_cnt, 32'd5);
`endif

        for (int i = 0; i < NBYTES / 4; i++)
            step(1'b1, 3'd2, 33'h400 + 33'(4 * i), 32'h0, 1'b0, 33'h4, 1'b0, 32'h0, "preload");

        for (int i = 0; i < 8; i++)
            step(tbl[i].st, tbl[i].w, tbl[i].sa, tbl[i].sd, tbl[i].ld, tbl[i].la,
                 tbl[i].chk, tbl[i].exp, $sformatf("table%0d", i));

        for (int i = 0; i < 500; i++) begin
            logic        st, ld;
            logic [2:0]  w;
            logic [32:0] sa, la;
            logic [31:0] sd, exp;
            int          kind;
            kind = $urandom_range(0, 39);
            st = ($urandom_range(0, 3) != 0);
            w  = 3'($urandom_range(0, 3));
            sd = $urandom;
            sa = rand_ram_addr();
            if (kind < 8) sa = {1'($urandom), 32'h0};
            else if (kind == 8) begin
                sa = SADDR;
                sd = ($urandom_range(0, 1) != 0) ? PASS_V : (($urandom_range(0, 3) == 0) ? FAIL_V : sd);
            end
            ld = ($urandom_range(0, 1) != 0);
            la = ($urandom_range(0, 3) == 0) ? {1'($urandom), 32'h0} : rand_ram_addr();
            exp = model_load(la);
            step(st, w, sa, sd, ld, la, 1'b1, exp, $sformatf("rand%0d", i));
        end

        reset_dut("rst_stack");
        push(32'd1); push(32'd2); push(32'd3);
        pop(32'd3, "pop3"); pop(32'd2, "pop2"); pop(32'd1, "pop1");
        pop(32'd0, "pop_empty");
        check32("stack_unf_set", {31'h0, stack_unf}, 32'h1);

        reset_dut("rst_ovf");
        for (int i = 0; i <= DEPTH; i++) push(32'd10 + 32'(i));
        check32("stack_ovf_set", {31'h0, stack_ovf}, 32'h1);
        pop(32'd10 + 32'(DEPTH - 1), "pop_after_ovf");
        step(1'b1, 3'd2, 33'h0, 32'd7, 1'b1, 33'h0, 1'b1, 32'd12, "pushpop_old_top");
        pop(32'd7, "pop_replaced");
        pop(32'd11, "pop_below1");
        pop(32'd10, "pop_below2");
        pop(32'd0, "pop_drained");

        reset_dut("rst_pp_empty");
        step(1'b1, 3'd2, 33'h0, 32'd9, 1'b1, 33'h0, 1'b1, 32'd0, "pushpop_empty");
        check32("pp_empty_no_unf", {31'h0, stack_unf}, 32'h0);
        pop(32'd9, "pop_after_pp_empty");

        reset_dut("rst_pass");
        status_store(PASS_V);
        check32("pass_after_one", {31'h0, test_pass}, 32'h0);
        status_store(PASS_V);
        check32("pass_after_two", {31'h0, test_pass}, 32'h1);
        check32("pass_cnt_two", {24'h0, pass_cnt}, 32'd2);
`ifdef RV_DMEM_STATS_EN
        cc_snap = cycle_cnt;
`endif
        status_store(PASS_V);
        status_store(FAIL_V);
        check32("status_ignored", {23'h0, test_fail, pass_cnt}, 32'd2);
        step(1'b0, 3'd0, 33'h4, 32'h0, 1'b0, 33'h4, 1'b0, 32'h0, "idle");
        step(1'b0, 3'd0, 33'h4, 32'h0, 1'b0, 33'h4, 1'b0, 32'h0, "idle");
`ifdef RV_DMEM_STATS_EN
        check32("cycle_cnt_frozen", cycle_cnt, cc_snap);
`endif

        reset_dut("rst_fail");
        status_store(FAIL_V);
        check32("fail_set", {31'h0, test_fail}, 32'h1);
        status_store(PASS_V);
        status_store(PASS_V);
        check32("pass_blocked", {23'h0, test_pass, pass_cnt}, 32'h0);
        step(1'b1, 3'd2, 33'h200, 32'h12345678, 1'b0, 33'h4, 1'b0, 32'h0, "ram_after_fail_st");
        step(1'b0, 3'd0, 33'h4, 32'h0, 1'b1, 33'h200, 1'b1, 32'h12345678, "ram_after_fail_ld");
        reset_dut("rst_final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rv_dmem_mmio.md
# rv_dmem_mmio

Synthesizable, parametrised data-memory and test-status block for the RV32IMC_1P core's load/store port. It replaces the ad-hoc bench memory with four functions: a byte-addressed RAM, a bounded LIFO stack window at address 0, a pass/fail status register, and optional run statistics. It connects directly to the core's dmem_* ports and is usable both in simulation benches and on FPGA.

## Interface
Parameters:
- ADDR_W, 20: byte-address width of the RAM; depth is 2^ADDR_W bytes.
- STACK_DEPTH, 16: number of 32-bit LIFO entries at address 0; power of two, at least 2.
- STATUS_ADDR, 32'h1001200c: address of the status register.
- PASS_CODE, 32'h00400000: status store value that counts one pass.
- FAIL_CODE, 32'h00080000: status store value that flags a failure.
- PASS_TARGET, 2: number of passes required for test_pass.

Ports:
- clk, in, 1: clock.
- c_arst, in, 1: reset, asynchronous, active-high.
- c_dmem_store, in, 1: store strobe.
- dmem_store_width, in, 3: 0 = byte, 1 = half, bit1 set = word.
- dmem_store_addr, in, 33: store byte address; bit 32 is ignored.
- dmem_store_data, in, 32: store data, LSB-aligned.
- c_dmem_load, in, 1: load strobe.
- dmem_load_addr, in, 33: load byte address; bit 32 is ignored.
- dmem_load_data, out, 32: load data, combinational.
- test_pass, out, 1: sticky; set when pass_cnt reaches PASS_TARGET.
- test_fail, out, 1: sticky; set on a FAIL_CODE store.
- pass_cnt, out, 8: saturating count of PASS_CODE stores.
- stack_ovf, out, 1: sticky; set on a push while the stack is full.
- stack_unf, out, 1: sticky; set on a pop while the stack is empty.
- cycle_cnt, out, 32: present only with RV_DMEM_STATS_EN.

## Operation
- Address decode uses addr[31:0]. Priority: address 0 (stack), then STATUS_ADDR, then RAM.
- **RAM store**
  - Writes byte addr[ADDR_W-1:0] + k for k < 1, 2 or 4 bytes, according to width.
  - Any alignment is accepted; the byte index wraps modulo 2^ADDR_W.
  - RAM contents are not reset; the bench preloads them.
- **RAM load**
  - Always returns 4 little-endian bytes starting at addr[ADDR_W-1:0], with the same wrap rule.
  - The core performs sign/zero extension.
- **Stack**
  - A store to address 0 pushes dmem_store_data: mem[sp] <= data, then sp++.
  - A load strobe at address 0 pops: sp--.
  - dmem_load_data at address 0 is mem[sp-1], or 0 when the stack is empty.
  - Push when full: dropped, sp unchanged, stack_ovf set.
  - Pop when empty: sp unchanged, returns 0, stack_unf set.
  - Push and pop in the same cycle, stack non-empty: the top entry is replaced by the store data; sp unchanged; load data shows the old top.
  - Push and pop in the same cycle, stack empty: treated as push only; no underflow is flagged.
- **Status register**
  - A store to STATUS_ADDR does not write RAM.
  - PASS_CODE: pass_cnt++ (saturates at 255).
  - FAIL_CODE: test_fail set.
  - Any other value: ignored.
- **Run state**
  - running = !(test_pass | test_fail).
  - Once not running, status stores are ignored; RAM and stack stay functional.

## Timing
- Stores take effect at the rising clk edge; a load in the following cycle sees the new data.
- Load data is combinational from the address and current state, so a same-cycle store is not forwarded.
- test_pass is registered. It is high in the cycle after the store that makes pass_cnt equal PASS_TARGET.
- test_fail is registered. It is high in the cycle after the FAIL_CODE store.
- If PASS_CODE and the target are reached while test_fail is already set, test_pass stays 0.
- Reset values: sp = 0, pass_cnt = 0, test_pass = 0, test_fail = 0, stack_ovf = 0, stack_unf = 0, cycle_cnt = 0.
- Reset mid-operation clears all of the above immediately (asynchronously); RAM and stack contents are retained.

## Configuration
- RV_DMEM_STATS_EN defined:
  - cycle_cnt increments every clk edge while running and not in reset.
  - It freezes when test_pass or test_fail is set and saturates at 32'hffffffff.
- RV_DMEM_STATS_EN undefined: the cycle_cnt port and its counter are absent.

## Structure
- Package rv_dmem_pkg holds:
  - width encodings: W_BYTE = 0, W_HALF = 1, W_WORD = 2;
  - default STATUS_ADDR, PASS_CODE and FAIL_CODE;
  - the pass-count width.
- Sub-module rv_dmem_stack holds the LIFO: pointer, full/empty, the simultaneous push/pop rule and the sticky flags.
- The RAM array, address decode and status logic stay in the top module.

## Test plan
- Store word 32'hdeadbeef to 0x100, then load 0x100 -> 32'hdeadbeef. Store byte 8'h55 to 0x102, then load 0x100 -> 32'hde55beef.
- Store half 16'hcafe to 2^ADDR_W-1 -> byte at the top address = 8'hfe and byte 0x0 = 8'hca (wrap).
- Push 1, 2, 3 to address 0, then pop three times -> 3, 2, 1. A fourth pop -> 0 and stack_unf = 1.
- Push STACK_DEPTH+1 values -> stack_ovf = 1; the first pop returns the STACK_DEPTH-th value.
- With the stack non-empty, push 7 and pop in the same cycle -> load shows the old top, sp unchanged, next pop returns 7.
- Two PASS_CODE stores to 0x1001200c -> test_pass = 1 one cycle after the second; cycle_cnt frozen (STATS_EN). Separately, a FAIL_CODE store -> test_fail = 1. Assert c_arst -> all flags 0 immediately.
